apb_master_bridge: RTL and testbench

- APB requester: converts single-beat commands from a local valid/ready request port into compliant APB SETUP/ACCESS transfers.
- Returns the read data and error status on a one-cycle response pulse.
- Sits in front of the existing 8-bit APB slave and drives the same bus that the bus assertions check. It is the initiator end of that link.
- Adds a bounded wait-state timeout so a hung slave cannot stall the initiator forever.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_bridge.sv | 130 +++++++++++++
 tb/tb_apb_master_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB bridge types, default widths and response record
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-beat command port to APB requester with wait-state timeout
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic              accept;
    logic              timeout_hit;

    assign cmd_ready   = (state_q == APB_IDLE) || ((state_q == APB_ACCESS) && pready);
    assign accept      = cmd_valid && cmd_ready;
    // Fires on the TIMEOUT-th wait cycle; a simultaneous pready takes priority below.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);
    assign busy        = (state_q != APB_IDLE);

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q       <= APB_IDLE;
            wait_cnt_q    <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            unique case (state_q)
                APB_IDLE: begin
                    if (accept) begin
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        rsp_err_q   <= pslverr;
                        penable_q   <= 1'b0;
                        if (accept) begin
                            pwrite_q <= cmd_write;
                            paddr_q  <= cmd_addr;
                            pwdata_q <= cmd_wdata;
                            state_q  <= APB_SETUP;
                        end else begin
                            psel_q  <= 1'b0;
                            state_q <= APB_IDLE;
                        end
                    end else if (timeout_hit) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= APB_IDLE;
                    end else if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= APB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
    import apb_pkg::*;

    logic       pclk = 1'b0;
    logic       prst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_err, rsp_timeout, busy;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite, pready, pslverr;
    logic [7:0] paddr, pwdata, prdata;

    logic [7:0] mem [256];
    int         wait_cfg;
    int         wcnt;
    logic       hang, err_cfg;
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;
    int         rsp_seen;
    int         n_checks;
    int         n_errors;

    always #5 pclk = ~pclk;

    apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Slave model: wait_cfg wait states per access, hang holds pready low forever.
    assign pready  = psel && penable && !hang && (wcnt >= wait_cfg);
    assign prdata  = mem[paddr];
    assign pslverr = err_cfg;

    always @(posedge pclk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (psel && penable) begin
            if (pready) begin
                wcnt <= 0;
                if (pwrite) mem[paddr] <= pwdata;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    always @(negedge pclk) if (rsp_valid) rsp_seen = rsp_seen + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic apb_rsp_t rsp_of(input logic [7:0] d, input logic e, input logic t);
        apb_rsp_t r;
        r.rdata   = d;
        r.err     = e;
        r.timeout = t;
        return r;
    endfunction

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        step();
        bd_we   = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the SETUP cycle.
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] psel_m, pen_m, rsp_m;
        int         idx;
        int         seen;
        logic       acc;

        n_checks = 0; n_errors = 0; rsp_seen = 0; wcnt = 0;
        prst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        wait_cfg = 0; hang = 1'b0; err_cfg = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (2) step();
        check("rst_outs", {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err,
                           rsp_timeout, rsp_rdata, busy}, 32'h0);
        check("rst_cmd_ready", cmd_ready, 1);
        prst = 1'b1;
        step();

        // Zero-wait write
        issue(1'b1, 8'h10, 8'hA5);
        check("t1_setup", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b0, 1'b1, 8'h10, 8'hA5});
        check("t1_setup_busy_rdy", {busy, cmd_ready}, 2'b10);
        step();
        check("t1_access", {psel, penable, cmd_ready}, 3'b111);
        step();
        check("t1_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, rsp_of(8'h00, 1'b0, 1'b0)});
        check("t1_idle_bus", {psel, penable, busy}, 3'b000);
        check("t1_mem", mem[8'h10], 8'hA5);
        step();
        check("t1_rsp_pulse", rsp_valid, 0);

        // Read with two wait states
        wait_cfg = 2;
        issue(1'b0, 8'h10, 8'h00);
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t2_access%0d", k), {psel, penable, paddr, pwrite, pready},
                  {1'b1, 1'b1, 8'h10, 1'b0, (k == 2) ? 1'b1 : 1'b0});
            check($sformatf("t2_norsp%0d", k), rsp_valid, 0);
            step();
        end
        check("t2_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, rsp_of(8'hA5, 1'b0, 1'b0)});
        wait_cfg = 0;

        // Back-to-back writes with cmd_valid held high
        psel_m = '0; pen_m = '0; rsp_m = '0; idx = 0;
        cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        for (int c = 1; c < 8; c++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                idx = idx + 1;
                if (idx < 3) begin
                    cmd_addr  = 8'(idx + 1);
                    cmd_wdata = 8'((idx + 1) * 8'h11);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            psel_m[c] = psel;
            pen_m[c]  = penable;
            rsp_m[c]  = rsp_valid;
        end
        check("t3_psel", psel_m, 8'h7E);
        check("t3_penable", pen_m, 8'h54);
        check("t3_rsp", rsp_m, 8'hA8);
        check("t3_mem", {mem[1], mem[2], mem[3]}, 24'h112233);

        // Slave error on read
        poke(8'hFF, 8'h5C);
        err_cfg = 1'b1;
        issue(1'b0, 8'hFF, 8'h00);
        step();
        step();
        check("t4_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, rsp_of(8'h5C, 1'b1, 1'b0)});
        err_cfg = 1'b0;

        // Timeout after four wait cycles
        poke(8'h20, 8'hEE);
        hang = 1'b1;
        issue(1'b0, 8'h20, 8'h00);
        repeat (4) step();
        check("t5_last_wait", {psel, penable, cmd_ready, busy, rsp_valid}, 5'b11010);
        step();
        check("t5_abort_bus", {psel, penable, busy}, 3'b000);
        check("t5_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, rsp_of(8'h00, 1'b1, 1'b1)});
        check("t5_ready", cmd_ready, 1);
        hang = 1'b0;
        issue(1'b1, 8'h30, 8'h77);
        step();
        step();
        check("t5_next_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, rsp_of(8'h00, 1'b0, 1'b0)});
        check("t5_next_mem", mem[8'h30], 8'h77);

        // pready on the threshold cycle completes normally
        wait_cfg = 3;
        issue(1'b0, 8'h10, 8'h00);
        repeat (4) step();
        check("t5b_edge_norsp", rsp_valid, 0);
        step();
        check("t5b_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, rsp_of(8'hA5, 1'b0, 1'b0)});

        // Reset in the second ACCESS cycle of a wait
        issue(1'b0, 8'h10, 8'h00);
        step();
        step();
        check("t6_in_access", {psel, penable}, 2'b11);
        seen = rsp_seen;
        prst = 1'b0;
        #1;
        check("t6_rst_outs", {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err,
                              rsp_timeout, rsp_rdata, busy}, 32'h0);
        step();
        step();
        check("t6_no_rsp", rsp_seen, seen);
        prst = 1'b1;
        wait_cfg = 0;
        issue(1'b0, 8'h10, 8'h00);
        step();
        step();
        check("t6_fresh_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, rsp_of(8'hA5, 1'b0, 1'b0)});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
